multi_tone_synth: RTL and testbench

//  N-channel tone generator: per-channel half-period counters, selectable waveform (square, 25% pulse,

---
 rtl/multi_tone_synth_pkg.sv | 33 +++
 rtl/multi_tone_synth_if.sv | 22 ++
 rtl/multi_tone_synth_channel.sv | 110 +++++++++++
 rtl/multi_tone_synth.sv | 73 +++++++
 tb/tb_multi_tone_synth.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_tone_synth_pkg.sv
// Shared definitions for the multi-channel tone synthesizer.
//   mode_e     : waveform select encodings (reserved code behaves as square)
//   LFSR_SEED  : noise generator reset value, non-zero so the LFSR never locks up
//   lfsr_next  : one step of the x^15 + x^14 + 1 noise generator
//   wave_bit   : waveform output for a given mode, phase and LFSR state
package multi_tone_synth_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE  = 2'b00,
    MODE_PULSE25 = 2'b01,
    MODE_NOISE   = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam logic [14:0] LFSR_SEED   = 15'h7FFF;
  localparam int          LFSR_TAP_HI = 14;
  localparam int          LFSR_TAP_LO = 13;

  function automatic logic [14:0] lfsr_next(input logic [14:0] s);
    return {s[13:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

  // Pulse is high only in the second quarter of the 4-half-period cycle.
  function automatic logic wave_bit(input mode_e m, input logic [1:0] phase,
                                    input logic [14:0] lfsr);
    case (m)
      MODE_PULSE25: return phase == 2'b01;
      MODE_NOISE:   return lfsr[14];
      default:      return phase[0];
    endcase
  endfunction

endpackage

// File: rtl/multi_tone_synth_if.sv
// Configuration write bus from the sequencer to the synthesizer.
//   cfg_we     : one-cycle write strobe, always accepted
//   cfg_ch     : target channel (out-of-range values are ignored by the slave)
//   cfg_hp     : half-period in clock cycles, 0 mutes the channel
//   cfg_mode   : waveform select (see mode_e)
//   cfg_active : channel enable
// master drives the bus, slave receives it.
interface multi_tone_synth_if #(
  parameter int CHANNELS = 4,
  parameter int HP_W     = 10
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [HP_W-1:0] cfg_hp;
  logic [1:0]      cfg_mode;
  logic            cfg_active;

  modport master (output cfg_we, cfg_ch, cfg_hp, cfg_mode, cfg_active);
  modport slave  (input  cfg_we, cfg_ch, cfg_hp, cfg_mode, cfg_active);
endinterface

// File: rtl/multi_tone_synth_channel.sv
// One tone channel: half-period counter, phase, noise LFSR, retune shadow
// registers and registered waveform output.
//   synth_clk : clock, all state on posedge
//   rst       : synchronous active-high reset
//   wr        : config write addressed to this channel
//   wr_hp     : written half-period (0 = muted)
//   wr_mode   : written waveform mode
//   wr_active : written enable
//   tone      : registered waveform bit
module multi_tone_synth_channel
  import multi_tone_synth_pkg::*;
#(
  parameter int HP_W = 10
) (
  input  logic            synth_clk,
  input  logic            rst,
  input  logic            wr,
  input  logic [HP_W-1:0] wr_hp,
  input  mode_e           wr_mode,
  input  logic            wr_active,
  output logic            tone
);

  logic [HP_W-1:0] hp, ctr, sh_hp, nxt_hp;
  mode_e           mode, sh_mode, nxt_mode;
  logic            active, sh_pend;
  logic [1:0]      phase;
  logic [14:0]     lfsr, nxt_lfsr;
  logic            running, expiry;

  assign running = active && (hp != '0);
  assign expiry  = running && (ctr == hp);

  // Settings for the half-period that starts at an expiry: a write landing on
  // the expiry cycle takes effect at once, otherwise a pending retune does.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    nxt_hp   = hp;
    nxt_mode = mode;
    if (wr) begin
      nxt_hp   = wr_hp;
      nxt_mode = wr_mode;
    end else if (sh_pend) begin
      nxt_hp   = sh_hp;
      nxt_mode = sh_mode;
    end
    nxt_lfsr = (nxt_mode == MODE_NOISE) ? lfsr_next(lfsr) : lfsr;
  end

  // NOTE: state updates use non-blocking assignments so every branch reads
  // the pre-edge values, independent of statement order.
  always_ff @(posedge synth_clk) begin
    if (rst) begin
      hp      <= '0;
      mode    <= MODE_SQUARE;
      active  <= 1'b0;
      ctr     <= HP_W'(1);
      phase   <= 2'b00;
      lfsr    <= LFSR_SEED;
      sh_hp   <= '0;
      sh_mode <= MODE_SQUARE;
      sh_pend <= 1'b0;
      tone    <= 1'b0;
    end else if (wr && !wr_active) begin
      // Disable is immediate; the LFSR keeps its state for the next enable.
      active  <= 1'b0;
      hp      <= wr_hp;
      mode    <= wr_mode;
      ctr     <= HP_W'(1);
      phase   <= 2'b00;
      sh_pend <= 1'b0;
      tone    <= 1'b0;
    end else if (wr && !running) begin
      // Idle channel: nothing to protect, load directly and restart counting.
      active  <= 1'b1;
      hp      <= wr_hp;
      mode    <= wr_mode;
      ctr     <= HP_W'(1);
      phase   <= 2'b00;
      sh_pend <= 1'b0;
      tone    <= 1'b0;
    end else if (expiry) begin
      hp      <= nxt_hp;
      mode    <= nxt_mode;
      sh_pend <= 1'b0;
      ctr     <= HP_W'(1);
      lfsr    <= nxt_lfsr;
      if (nxt_hp == '0) begin
        phase <= 2'b00;
        tone  <= 1'b0;
      end else begin
        phase <= phase + 2'd1;
        tone  <= wave_bit(nxt_mode, phase + 2'd1, nxt_lfsr);
      end
    end else if (running) begin
      ctr <= ctr + HP_W'(1);
      // Retune of a running channel waits for the boundary; last write wins.
      if (wr) begin
        sh_hp   <= wr_hp;
        sh_mode <= wr_mode;
        sh_pend <= 1'b1;
      end
    end else begin
      ctr   <= HP_W'(1);
      phase <= 2'b00;
      tone  <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_tone_synth.sv
// Multi-channel tone synthesizer top: config write decode, CHANNELS tone
// channels, popcount mixer and first-order 1-bit sigma-delta output.
//   synth_clk : clock, all state on posedge
//   rst       : synchronous active-high reset
//   cfg       : config write bus (slave)
//   ch_audio  : per-channel waveform bits (registered)
//   mix_out   : number of channels currently high (registered, 1 cycle later)
//   audio     : sigma-delta bitstream with density mix_out/CHANNELS
module multi_tone_synth
  import multi_tone_synth_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int HP_W     = 10,
  localparam int MIX_W    = $clog2(CHANNELS + 1)
) (
  input  logic                synth_clk,
  input  logic                rst,
  multi_tone_synth_if.slave   cfg,
  output logic [CHANNELS-1:0] ch_audio,
  output logic [MIX_W-1:0]    mix_out,
  output logic                audio
);

  localparam int             CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [MIX_W:0] FULL = (MIX_W + 1)'(CHANNELS);

  // Channel indices with no matching instance simply never get selected,
  // which is how out-of-range writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic sel;
    assign sel = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

    multi_tone_synth_channel #(.HP_W(HP_W)) u_ch (
      .synth_clk (synth_clk),
      .rst       (rst),
      .wr        (sel),
      .wr_hp     (cfg.cfg_hp),
      .wr_mode   (mode_e'(cfg.cfg_mode)),
      .wr_active (cfg.cfg_active),
      .tone      (ch_audio[i])
    );
  end

  logic [MIX_W-1:0] pop;
  logic [MIX_W-1:0] acc;
  logic [MIX_W:0]   sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) pop = pop + MIX_W'(ch_audio[i]);
  end

  // One extra bit holds acc + mix_out, whose maximum is 2*CHANNELS-1.
  assign sum = {1'b0, acc} + {1'b0, mix_out};

  always_ff @(posedge synth_clk) begin
    if (rst) begin
      mix_out <= '0;
      acc     <= '0;
      audio   <= 1'b0;
    end else begin
      mix_out <= pop;
      if (sum >= FULL) begin
        audio <= 1'b1;
        acc   <= MIX_W'(sum - FULL);
      end else begin
        audio <= 1'b0;
        acc   <= MIX_W'(sum);
      end
    end
  end

endmodule

// File: tb/tb_multi_tone_synth.sv
module tb_multi_tone_synth;

  localparam int NA = 4;
  localparam int NB = 5;

  logic synth_clk = 1'b0;
  logic rst;
  always #5 synth_clk = ~synth_clk;

  multi_tone_synth_if #(.CHANNELS(NA), .HP_W(10)) cfg_a ();
  multi_tone_synth_if #(.CHANNELS(NB), .HP_W(10)) cfg_b ();

  logic [NA-1:0] ch_audio;
  logic [2:0]    mix_out;
  logic          audio;
  logic [NB-1:0] ch_audio_b;
  logic [2:0]    mix_out_b;
  logic          audio_b;

  multi_tone_synth #(.CHANNELS(NA), .HP_W(10)) dut (
    .synth_clk (synth_clk),
    .rst       (rst),
    .cfg       (cfg_a),
    .ch_audio  (ch_audio),
    .mix_out   (mix_out),
    .audio     (audio)
  );

  // Second instance with a non-power-of-two channel count, so that
  // out-of-range channel numbers can actually be written.
  multi_tone_synth #(.CHANNELS(NB), .HP_W(10)) dut_b (
    .synth_clk (synth_clk),
    .rst       (rst),
    .cfg       (cfg_b),
    .ch_audio  (ch_audio_b),
    .mix_out   (mix_out_b),
    .audio     (audio_b)
  );

  int checks = 0;
  int errors = 0;
  bit model_on = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut (4 channels) ----------------
  // Each channel is described by its settings, the cycles left in the current
  // half-period, the number of half-periods elapsed and the noise register.
  int m_hp[NA], m_mode[NA], m_act[NA], m_left[NA], m_k[NA], m_lfsr[NA];
  int m_pend[NA], m_shp[NA], m_smode[NA];
  bit m_out[NA];
  int m_mix, m_acc;
  bit m_audio;

  function automatic int noise_step(input int s);
    int fb;
    fb = ((s >> 14) ^ (s >> 13)) & 1;
    return ((s * 2) % 32768) + fb;
  endfunction

  function automatic bit shape(input int mode, input int k, input int lfsr);
    if (mode == 1) return (k % 4) == 1;
    if (mode == 2) return ((lfsr >> 14) & 1) == 1;
    return (k % 2) == 1;
  endfunction

  always @(posedge synth_clk) begin
    if (rst) begin
      for (int i = 0; i < NA; i++) begin
        m_hp[i] = 0; m_mode[i] = 0; m_act[i] = 0; m_left[i] = 0; m_k[i] = 0;
        m_lfsr[i] = 32'h7FFF; m_pend[i] = 0; m_shp[i] = 0; m_smode[i] = 0; m_out[i] = 0;
      end
      m_mix = 0; m_acc = 0; m_audio = 0;
    end else begin
      int sum, nh, nm;
      bit hit, run;
      sum = m_acc + m_mix;
      m_audio = (sum >= NA);
      m_acc = m_audio ? sum - NA : sum;
      m_mix = 0;
      for (int i = 0; i < NA; i++) m_mix += int'(m_out[i]);
      for (int i = 0; i < NA; i++) begin
        hit = cfg_a.cfg_we && (int'(cfg_a.cfg_ch) == i);
        run = (m_act[i] != 0) && (m_hp[i] != 0);
        if (hit && !cfg_a.cfg_active) begin
          m_act[i] = 0; m_hp[i] = int'(cfg_a.cfg_hp); m_mode[i] = int'(cfg_a.cfg_mode);
          m_k[i] = 0; m_out[i] = 0; m_pend[i] = 0;
        end else if (hit && !run) begin
          m_act[i] = 1; m_hp[i] = int'(cfg_a.cfg_hp); m_mode[i] = int'(cfg_a.cfg_mode);
          m_left[i] = m_hp[i]; m_k[i] = 0; m_out[i] = 0; m_pend[i] = 0;
        end else if (run) begin
          if (m_left[i] == 1) begin
            nh = m_hp[i]; nm = m_mode[i];
            if (hit) begin
              nh = int'(cfg_a.cfg_hp); nm = int'(cfg_a.cfg_mode);
            end else if (m_pend[i] != 0) begin
              nh = m_shp[i]; nm = m_smode[i];
            end
            m_pend[i] = 0; m_hp[i] = nh; m_mode[i] = nm; m_left[i] = nh;
            if (nm == 2) m_lfsr[i] = noise_step(m_lfsr[i]);
            if (nh == 0) begin
              m_k[i] = 0; m_out[i] = 0;
            end else begin
              m_k[i] = m_k[i] + 1;
              m_out[i] = shape(nm, m_k[i], m_lfsr[i]);
            end
          end else begin
            m_left[i] = m_left[i] - 1;
            if (hit) begin
              m_shp[i] = int'(cfg_a.cfg_hp); m_smode[i] = int'(cfg_a.cfg_mode); m_pend[i] = 1;
            end
          end
        end else begin
          m_k[i] = 0; m_out[i] = 0;
        end
      end
    end
  end

  logic [31:0] exp_v;
  always @(negedge synth_clk) begin
    if (model_on) begin
      exp_v = '0;
      for (int i = 0; i < NA; i++) exp_v[4+i] = m_out[i];
      exp_v[3:1] = 3'(m_mix);
      exp_v[0]   = m_audio;
      check("model_cycle", {24'b0, ch_audio, mix_out, audio}, exp_v);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(negedge synth_clk);
    rst = 1'b0;
  endtask

  task automatic do_write(input int ch, input int hp, input int mode, input bit act);
    cfg_a.cfg_ch = 2'(ch); cfg_a.cfg_hp = 10'(hp); cfg_a.cfg_mode = 2'(mode);
    cfg_a.cfg_active = act; cfg_a.cfg_we = 1'b1;
    @(negedge synth_clk);
    cfg_a.cfg_we = 1'b0;
  endtask

  task automatic do_write_b(input int ch, input int hp, input int mode, input bit act);
    cfg_b.cfg_ch = 3'(ch); cfg_b.cfg_hp = 10'(hp); cfg_b.cfg_mode = 2'(mode);
    cfg_b.cfg_active = act; cfg_b.cfg_we = 1'b1;
    @(negedge synth_clk);
    cfg_b.cfg_we = 1'b0;
  endtask

  logic [11:0] s12;
  logic [15:0] s16;

  initial begin
    cfg_a.cfg_we = 0; cfg_a.cfg_ch = '0; cfg_a.cfg_hp = '0; cfg_a.cfg_mode = '0; cfg_a.cfg_active = 0;
    cfg_b.cfg_we = 0; cfg_b.cfg_ch = '0; cfg_b.cfg_hp = '0; cfg_b.cfg_mode = '0; cfg_b.cfg_active = 0;
    rst = 1'b1;
    @(negedge synth_clk);
    rst = 1'b0;
    model_on = 1;

    check("reset_ch_audio", 32'(ch_audio), 32'h0);
    check("reset_mix_out",  32'(mix_out),  32'h0);
    check("reset_audio",    32'(audio),    32'h0);
    check("reset_b_all",    32'({ch_audio_b, mix_out_b, audio_b}), 32'h0);

    // ch0 square hp=3: first rise 3 cycles after write+1, then 3 high / 3 low.
    do_write(0, 3, 0, 1);
    for (int n = 1; n <= 12; n++) begin
      @(negedge synth_clk);
      s12[12-n] = ch_audio[0];
    end
    check("square_hp3", 32'(s12), 32'(12'b001110001110));

    // ch1 pulse25 hp=2: high 2, low 6.
    do_write(1, 2, 1, 1);
    for (int n = 1; n <= 12; n++) begin
      @(negedge synth_clk);
      s12[12-n] = ch_audio[1];
    end
    check("pulse25_hp2", 32'(s12), 32'(12'b011000000110));

    // Reset with two tones running: everything back to zero on that edge.
    repeat (3) @(negedge synth_clk);
    do_reset();
    check("midtone_reset", 32'({ch_audio, mix_out, audio}), 32'h0);

    // Retune hp 5 -> 2 in the middle of a half-period.
    do_write(0, 5, 0, 1);
    for (int n = 1; n <= 16; n++) begin
      if (n == 7) begin
        cfg_a.cfg_ch = 2'd0; cfg_a.cfg_hp = 10'd2; cfg_a.cfg_mode = 2'd0;
        cfg_a.cfg_active = 1'b1; cfg_a.cfg_we = 1'b1;
      end else begin
        cfg_a.cfg_we = 1'b0;
      end
      @(negedge synth_clk);
      s16[16-n] = ch_audio[0];
    end
    cfg_a.cfg_we = 1'b0;
    check("retune_5_to_2", 32'(s16), 32'(16'b0000111110011001));

    // Noise hp=1 on ch2: fixed opening sequence, repeating after 32767 steps.
    do_reset();
    do_write(2, 1, 2, 1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge synth_clk);
      s16[16-n] = ch_audio[2];
    end
    check("noise_start", 32'(s16), 32'hFFFC);
    repeat (32767 - 16) @(negedge synth_clk);
    for (int n = 1; n <= 16; n++) begin
      @(negedge synth_clk);
      s16[16-n] = ch_audio[2];
    end
    check("noise_period", 32'(s16), 32'hFFFC);

    // Four squares overlapping high: full-scale mix, audio constant 1.
    do_reset();
    for (int c = 0; c < NA; c++) do_write(c, 8, 0, 1);
    repeat (11) @(negedge synth_clk);
    check("all_high_mix",   32'(mix_out), 32'd4);
    check("all_high_audio", 32'(audio),   32'd1);

    // Two of four high: audio alternates.
    do_reset();
    do_write(0, 8, 0, 1);
    do_write(1, 8, 0, 1);
    repeat (11) @(negedge synth_clk);
    check("half_audio_a", 32'(audio), 32'd1);
    @(negedge synth_clk);
    check("half_audio_b", 32'(audio), 32'd0);
    @(negedge synth_clk);
    check("half_audio_c", 32'(audio), 32'd1);

    // hp=0 on a running channel mutes it at the next boundary, not before.
    do_reset();
    do_write(0, 3, 0, 1);
    repeat (4) @(negedge synth_clk);
    do_write(0, 0, 0, 1);
    check("mute_holds_half", 32'(ch_audio[0]), 32'd1);
    @(negedge synth_clk);
    check("mute_applied", 32'(ch_audio[0]), 32'd0);
    do_write(1, 0, 0, 1);
    repeat (8) @(negedge synth_clk);
    check("muted_silent", 32'({ch_audio, mix_out, audio}), 32'h0);

    // Out-of-range channel writes are ignored; the last valid channel works.
    do_write_b(7, 1, 0, 1);
    do_write_b(5, 1, 0, 1);
    repeat (4) @(negedge synth_clk);
    check("bad_ch_ignored", 32'({ch_audio_b, mix_out_b, audio_b}), 32'h0);
    do_write_b(4, 1, 0, 1);
    check("last_ch_start", 32'(ch_audio_b), 32'h0);
    @(negedge synth_clk);
    check("last_ch_high", 32'(ch_audio_b), 32'h10);
    @(negedge synth_clk);
    check("last_ch_low", 32'(ch_audio_b), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
